// File: rtl/ef_spi_master_mc.sv
// ef_spi_master_mc
//   Full-duplex SPI master with configurable word width, NCS active-low chip
//   selects, all four CPOL/CPHA modes, a programmable SCLK divider and
//   chip-select hold across words for multi-word frames.
//
//   Optional feature macro: EF_SPI_LSB_FIRST_EN
//     Defined   : adds input lsb_first (sampled at go); 1 shifts LSB first.
//     Undefined : MSB first always. Timing is identical in both builds.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   cpol, cpha        SPI mode, sampled at go
//   clk_div           SCLK half period = clk_div+1 clk cycles, sampled at go
//   cs_sel, cs_hold   chip-select index and hold-after-word flag, sampled at go
//   go, datai         start pulse (accepted while busy=0) and TX word
//   datao, busy, done RX word (valid from done), in-progress flag, done pulse
//   miso, mosi, sclk  serial pads
//   csb               active-low chip selects

module ef_spi_master_mc #(
   parameter int unsigned DW  = 8,
   parameter int unsigned CDW = 8,
   parameter int unsigned NCS = 1,
   parameter int unsigned SW  = (NCS > 1) ? $clog2(NCS) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cpol,
   input  logic           cpha,
   input  logic [CDW-1:0] clk_div,
   input  logic [SW-1:0]  cs_sel,
   input  logic           cs_hold,
   input  logic           go,
   input  logic [DW-1:0]  datai,
`ifdef EF_SPI_LSB_FIRST_EN
   input  logic           lsb_first,
`endif
   output logic [DW-1:0]  datao,
   output logic           busy,
   output logic           done,
   input  logic           miso,
   output logic           mosi,
   output logic           sclk,
   output logic [NCS-1:0] csb
);

   localparam int unsigned EW = $clog2(2 * DW);
   localparam logic [EW-1:0] LastEdge = EW'(2 * DW - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

   state_e         state_q, state_d;
   logic [CDW-1:0] cnt_q, cnt_d;
   logic [CDW-1:0] div_q, div_d;
   logic [EW-1:0]  edge_q, edge_d;
   logic [DW-1:0]  tx_q, tx_d;
   logic [DW-1:0]  rx_q, rx_d;
   logic [DW-1:0]  datao_q, datao_d;
   logic [NCS-1:0] csb_q, csb_d;
   logic           cpha_q, cpha_d;
   logic           hold_q, hold_d;
   logic           lsb_q, lsb_d;
   logic           sclk_q, sclk_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic           lsb_in;
   logic           half_end;
   logic           do_edge;
   logic [EW-1:0]  edge_k;
   logic           lead;
   logic           do_sample;
   logic           do_shift;

`ifdef EF_SPI_LSB_FIRST_EN
   assign lsb_in = lsb_first;
`else
   assign lsb_in = 1'b0;
`endif

   // Down-counter reloads from the latched divider, so clk_div all-ones never wraps.
   assign half_end = (cnt_q == '0);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      edge_d   = edge_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      datao_d  = datao_q;
      csb_d    = csb_q;
      cpha_d   = cpha_q;
      hold_d   = hold_q;
      lsb_d    = lsb_q;
      sclk_d   = sclk_q;
      done_d   = 1'b0;
      do_edge  = 1'b0;
      edge_k   = '0;

      unique case (state_q)
         StIdle: begin
            // Idle level tracks cpol with one cycle of lag.
            sclk_d = cpol;
            if (go) begin
               state_d = StSetup;
               cnt_d   = clk_div;
               div_d   = clk_div;
               cpha_d  = cpha;
               hold_d  = cs_hold;
               lsb_d   = lsb_in;
               tx_d    = datai;
               edge_d  = '0;
               // Rebuilding csb in one assignment keeps a reselected CS low without a glitch.
               for (int i = 0; i < NCS; i++) begin
                  csb_d[i] = (cs_sel != SW'(i));
               end
            end
         end
         StSetup: begin
            if (half_end) begin
               state_d = StShift;
               cnt_d   = div_q;
               do_edge = 1'b1;
               edge_k  = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StShift: begin
            if (half_end) begin
               cnt_d = div_q;
               if (edge_q == LastEdge) begin
                  // Last edge already returned sclk to cpol.
                  state_d = StHold;
               end else begin
                  do_edge = 1'b1;
                  edge_k  = edge_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StHold: begin
            if (half_end) begin
               state_d = StIdle;
               done_d  = 1'b1;
               datao_d = rx_q;
               if (!hold_q) begin
                  csb_d = '1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Even edge indices are leading edges. The first bit is presented from
      // go, so cpha=1 skips the shift on edge 0 and cpha=0 skips it on the last.
      lead      = ~edge_k[0];
      do_sample = cpha_q ? ~lead : lead;
      do_shift  = cpha_q ? (lead && (edge_k != '0)) : (~lead && (edge_k != LastEdge));

      if (do_edge) begin
         sclk_d = ~sclk_q;
         edge_d = edge_k;
         if (do_sample) begin
            rx_d = lsb_q ? {miso, rx_q[DW-1:1]} : {rx_q[DW-2:0], miso};
         end
         if (do_shift) begin
            tx_d = lsb_q ? (tx_q >> 1) : (tx_q << 1);
         end
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         div_q   <= '0;
         edge_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         datao_q <= '0;
         csb_q   <= '1;
         cpha_q  <= 1'b0;
         hold_q  <= 1'b0;
         lsb_q   <= 1'b0;
         sclk_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         edge_q  <= edge_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         datao_q <= datao_d;
         csb_q   <= csb_d;
         cpha_q  <= cpha_d;
         hold_q  <= hold_d;
         lsb_q   <= lsb_d;
         sclk_q  <= sclk_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign datao = datao_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign sclk  = sclk_q;
   assign csb   = csb_q;
   assign mosi  = lsb_q ? tx_q[0] : tx_q[DW-1];

endmodule

// File: tb/tb_ef_spi_master_mc.sv
// Directed bench for ef_spi_master_mc (DW=8, CDW=8, NCS=4).
module tb_ef_spi_master_mc;

   localparam int unsigned DW  = 8;
   localparam int unsigned CDW = 8;
   localparam int unsigned NCS = 4;
   localparam int unsigned SW  = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           cpol = 1'b0;
   logic           cpha = 1'b0;
   logic [CDW-1:0] clk_div = '0;
   logic [SW-1:0]  cs_sel = '0;
   logic           cs_hold = 1'b0;
   logic           go = 1'b0;
   logic [DW-1:0]  datai = '0;
   logic [DW-1:0]  datao;
   logic           busy;
   logic           done;
   logic           miso;
   logic           mosi;
   logic           sclk;
   logic [NCS-1:0] csb;
   logic           lsb_first = 1'b0;

   logic           loop_en = 1'b1;
   logic [7:0]     sreg = '0;
   int             sedge = 0;
   int             edges = 0;
   int             rises = 0;
   int             done_cnt = 0;
   int             c2_rise = 0;
   int             c2_fall = 0;
   int             other_low = 0;
   logic           mon_en = 1'b0;
   int             vectors = 0;
   int             fails = 0;

   ef_spi_master_mc #(
      .DW (DW),
      .CDW(CDW),
      .NCS(NCS),
      .SW (SW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cpol     (cpol),
      .cpha     (cpha),
      .clk_div  (clk_div),
      .cs_sel   (cs_sel),
      .cs_hold  (cs_hold),
      .go       (go),
      .datai    (datai),
`ifdef EF_SPI_LSB_FIRST_EN
      .lsb_first(lsb_first),
`endif
      .datao    (datao),
      .busy     (busy),
      .done     (done),
      .miso     (miso),
      .mosi     (mosi),
      .sclk     (sclk),
      .csb      (csb)
   );

   always #5 clk = ~clk;

   // Slave: presents sreg[7]; shifts on trailing edges (cpha=0) or on
   // leading edges after the first (cpha=1).
   assign miso = loop_en ? mosi : sreg[7];

   always @(sclk) begin
      if (busy) begin
         edges++;
         if (sclk) rises++;
         if (cpha ? ((sedge % 2 == 0) && (sedge > 0)) : (sedge % 2 == 1)) sreg = sreg << 1;
         sedge++;
      end
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (mon_en && (csb[0] == 1'b0 || csb[1] == 1'b0 || csb[3] == 1'b0)) other_low++;
   end

   always @(posedge csb[2]) if (mon_en) c2_rise++;
   always @(negedge csb[2]) if (mon_en) c2_fall++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One word: configure, pulse go, count busy cycles. Returns in the first busy=0 cycle.
   task automatic xfer(input logic [7:0] d, input logic pl, input logic ph,
                       input logic [7:0] dv, input logic [1:0] sel, input logic hold,
                       input logic [7:0] sdata, output int blen, output logic m0);
      @(negedge clk);
      cpol = pl; cpha = ph; clk_div = dv; cs_sel = sel; cs_hold = hold; datai = d;
      sreg = sdata; sedge = 0; edges = 0; rises = 0;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      m0 = mosi;
      blen = 0;
      while (busy === 1'b1 && blen < 20000) begin
         blen++;
         @(negedge clk);
      end
   endtask

   int   blen;
   logic m0;
   int   dc;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_datao", datao, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_sclk", sclk, 0);
      chk("rst_csb", csb, 4'hF);
      rst = 1'b0;

      // 1: mode 0, div 1, loopback 0xA5
      loop_en = 1'b1;
      dc = done_cnt;
      xfer(8'hA5, 1'b0, 1'b0, 8'd1, 2'd0, 1'b0, 8'h00, blen, m0);
      chk("t1_busy_len", blen, 36);
      chk("t1_first_mosi", m0, 1);
      chk("t1_rises", rises, 8);
      chk("t1_edges", edges, 16);
      chk("t1_done", done, 1);
      chk("t1_datao", datao, 8'hA5);
      chk("t1_csb_release", csb, 4'hF);
      @(negedge clk);
      chk("t1_done_low", done, 0);
      chk("t1_done_count", done_cnt - dc, 1);

      // 2: all four modes against a slave returning 0x3C
      loop_en = 1'b0;
      for (int m = 0; m < 4; m++) begin
         xfer(8'h96, m[1], m[0], 8'd2, 2'd0, 1'b0, 8'h3C, blen, m0);
         chk($sformatf("t2_m%0d_datao", m), datao, 8'h3C);
         chk($sformatf("t2_m%0d_edges", m), edges, 16);
         chk($sformatf("t2_m%0d_sclk_idle", m), sclk, m[1]);
         chk($sformatf("t2_m%0d_busy_len", m), blen, 54);
      end
      loop_en = 1'b1;

      // 3: held CS across two words on cs_sel=2
      c2_rise = 0; c2_fall = 0; other_low = 0; mon_en = 1'b1;
      xfer(8'h11, 1'b0, 1'b0, 8'd1, 2'd2, 1'b1, 8'h00, blen, m0);
      chk("t3_w1_datao", datao, 8'h11);
      chk("t3_w1_csb_held", csb, 4'b1011);
      xfer(8'h22, 1'b0, 1'b0, 8'd1, 2'd2, 1'b0, 8'h00, blen, m0);
      chk("t3_w2_datao", datao, 8'h22);
      chk("t3_w2_csb_release", csb, 4'hF);
      chk("t3_cs2_falls", c2_fall, 1);
      chk("t3_cs2_rises", c2_rise, 1);
      chk("t3_other_cs_low", other_low, 0);
      mon_en = 1'b0;

      // 4a: go while busy is ignored
      @(negedge clk);
      cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1; cs_sel = 2'd0; cs_hold = 1'b0;
      datai = 8'h5A;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      blen = 0;
      repeat (8) begin
         blen++;
         @(negedge clk);
      end
      datai = 8'hFF; cs_sel = 2'd1; go = 1'b1;
      blen++;
      @(negedge clk);
      go = 1'b0;
      chk("t4_csb_unchanged", csb, 4'b1110);
      chk("t4_busy_mid", busy, 1);
      while (busy === 1'b1 && blen < 20000) begin
         blen++;
         @(negedge clk);
      end
      chk("t4_busy_len", blen, 36);
      chk("t4_datao", datao, 8'h5A);
      chk("t4_done", done, 1);
      @(negedge clk);
      chk("t4_no_restart", busy, 0);

      // 4b: reset mid-transfer aborts without done
      datai = 8'h33; cs_sel = 2'd3; cs_hold = 1'b1; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (10) @(negedge clk);
      dc = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_csb", csb, 4'hF);
      repeat (50) @(negedge clk);
      chk("t4_rst_no_done", done_cnt - dc, 0);
      chk("t4_rst_idle", busy, 0);

      // 5: divider extremes
      xfer(8'hC3, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 8'h00, blen, m0);
      chk("t5_div0_len", blen, 18);
      chk("t5_div0_datao", datao, 8'hC3);
      xfer(8'h69, 1'b0, 1'b0, 8'd255, 2'd0, 1'b0, 8'h00, blen, m0);
      chk("t5_div255_len", blen, 4608);
      chk("t5_div255_datao", datao, 8'h69);

`ifdef EF_SPI_LSB_FIRST_EN
      // 6: LSB-first loopback
      lsb_first = 1'b1;
      xfer(8'h01, 1'b0, 1'b0, 8'd1, 2'd0, 1'b0, 8'h00, blen, m0);
      chk("t6_first_mosi", m0, 1);
      chk("t6_datao", datao, 8'h01);
      chk("t6_busy_len", blen, 36);
      loop_en = 1'b0;
      xfer(8'h00, 1'b0, 1'b0, 8'd1, 2'd0, 1'b0, 8'h80, blen, m0);
      // Slave sends 1 first; it must land in datao[0].
      chk("t6_first_bit_lsb", datao, 8'h01);
      loop_en = 1'b1;
      lsb_first = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
